// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - MEM-stage exception controller bus: pipeline/CP0 inputs and CP0/flush outputs
interface exc_ctrl_if;
    logic [5:0]  int_i;
    logic [5:0]  int_sync_o;
    logic [31:0] excepttype_raw_i;
    logic [31:0] inst_addr_i;
    logic        is_in_delayslot_i;
    logic        inst_valid_i;
    logic        stall_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output int_i, excepttype_raw_i, inst_addr_i, is_in_delayslot_i, inst_valid_i, stall_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  int_sync_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
    );

    modport slave (
        input  int_i, excepttype_raw_i, inst_addr_i, is_in_delayslot_i, inst_valid_i, stall_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output int_sync_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception resolver and flush controller (EXC_CTRL_INT_SYNC_EN enables interrupt synchronizer)
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst,
    exc_ctrl_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [31:0] CODE_INT  = 32'h00000001;
    localparam logic [31:0] CODE_SYS  = 32'h00000008;
    localparam logic [31:0] CODE_INV  = 32'h0000000a;
    localparam logic [31:0] CODE_TRAP = 32'h0000000d;
    localparam logic [31:0] CODE_OV   = 32'h0000000c;
    localparam logic [31:0] CODE_ERET = 32'h0000000e;

    logic [0:0]  state;
    logic [2:0]  cnt;
    logic [31:0] excepttype_q;
    logic [31:0] cur_addr_q;
    logic        ds_q;
    logic        flush_q;
    logic [31:0] new_pc_q;

    logic [31:0] status_f;
    logic [31:0] cause_f;
    logic [31:0] epc_f;
    logic        int_pend;
    logic        det_en;
    logic [31:0] code;

    // A WB-stage mtc0 has not reached CP0 yet, so its value overrides the registered CP0 state
    always_comb begin
        status_f = cp0_status_sel(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, bus.wb_cp0_data_i, bus.cp0_status_i, 5'd12);
        epc_f    = cp0_status_sel(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, bus.wb_cp0_data_i, bus.cp0_epc_i, 5'd14);
        cause_f  = bus.cp0_cause_i;
        if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) begin
            cause_f[9:8] = bus.wb_cp0_data_i[9:8];
        end
    end

    function automatic logic [31:0] cp0_status_sel(input logic we, input logic [4:0] waddr,
                                                   input logic [31:0] wdata, input logic [31:0] cur,
                                                   input logic [4:0] reg_addr);
        return (we && waddr == reg_addr) ? wdata : cur;
    endfunction

    // Priority select of one exception code; zero means nothing to take
    always_comb begin
        int_pend = (|(cause_f[15:8] & status_f[15:8])) && !status_f[1] && status_f[0];
        det_en   = (state == S_IDLE) && bus.inst_valid_i && !bus.stall_i;
        code     = 32'h0;
        if (int_pend)                     code = CODE_INT;
        else if (bus.excepttype_raw_i[8])  code = CODE_SYS;
        else if (bus.excepttype_raw_i[9])  code = CODE_INV;
        else if (bus.excepttype_raw_i[10]) code = CODE_TRAP;
        else if (bus.excepttype_raw_i[11]) code = CODE_OV;
        else if (bus.excepttype_raw_i[12]) code = CODE_ERET;
    end

    // IDLE/FLUSH sequencer: capture the exception for one cycle, then hold flush for FLUSH_CYCLES
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            excepttype_q <= 32'h0;
            cur_addr_q   <= 32'h0;
            ds_q         <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= 32'h0;
        end else begin
            excepttype_q <= 32'h0;
            if (state == S_IDLE) begin
                if (det_en && code != 32'h0) begin
                    excepttype_q <= code;
                    cur_addr_q   <= bus.inst_addr_i;
                    ds_q         <= bus.is_in_delayslot_i;
                    flush_q      <= 1'b1;
                    new_pc_q     <= (code == CODE_ERET) ? epc_f : EXC_VECTOR;
                    cnt          <= 3'(FLUSH_CYCLES - 1);
                    state        <= S_FLUSH;
                end
            end else begin
                if (cnt == 3'd0) begin
                    state    <= S_IDLE;
                    flush_q  <= 1'b0;
                    new_pc_q <= 32'h0;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

    assign bus.excepttype_o        = excepttype_q;
    assign bus.current_inst_addr_o = cur_addr_q;
    assign bus.is_in_delayslot_o   = ds_q;
    assign bus.flush_o             = flush_q;
    assign bus.new_pc_o            = new_pc_q;

`ifdef EXC_CTRL_INT_SYNC_EN
    logic [5:0] int_meta;
    logic [5:0] int_sync;

    // Two-flop synchronizer for asynchronous interrupt lines; runs regardless of stall/flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_meta <= 6'h0;
            int_sync <= 6'h0;
        end else begin
            int_meta <= bus.int_i;
            int_sync <= int_meta;
        end
    end

    assign bus.int_sync_o = int_sync;
`else
    assign bus.int_sync_o = bus.int_i;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.excepttype_raw_i[31:13], bus.excepttype_raw_i[7:0],
                           status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl (FLUSH_CYCLES 1 and 3)
module tb_exc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    exc_ctrl_if bus1 ();
    exc_ctrl_if bus3 ();

    assign bus3.int_i             = bus1.int_i;
    assign bus3.excepttype_raw_i  = bus1.excepttype_raw_i;
    assign bus3.inst_addr_i       = bus1.inst_addr_i;
    assign bus3.is_in_delayslot_i = bus1.is_in_delayslot_i;
    assign bus3.inst_valid_i      = bus1.inst_valid_i;
    assign bus3.stall_i           = bus1.stall_i;
    assign bus3.cp0_status_i      = bus1.cp0_status_i;
    assign bus3.cp0_cause_i       = bus1.cp0_cause_i;
    assign bus3.cp0_epc_i         = bus1.cp0_epc_i;
    assign bus3.wb_cp0_we_i       = bus1.wb_cp0_we_i;
    assign bus3.wb_cp0_waddr_i    = bus1.wb_cp0_waddr_i;
    assign bus3.wb_cp0_data_i     = bus1.wb_cp0_data_i;

    exc_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    exc_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus1.int_i             = 6'h0;
        bus1.excepttype_raw_i  = 32'h0;
        bus1.inst_addr_i       = 32'h0;
        bus1.is_in_delayslot_i = 1'b0;
        bus1.inst_valid_i      = 1'b0;
        bus1.stall_i           = 1'b0;
        bus1.cp0_status_i      = 32'h0;
        bus1.cp0_cause_i       = 32'h0;
        bus1.cp0_epc_i         = 32'h0;
        bus1.wb_cp0_we_i       = 1'b0;
        bus1.wb_cp0_waddr_i    = 5'h0;
        bus1.wb_cp0_data_i     = 32'h0;

        step(2);
        chk("rst_exc", bus1.excepttype_o, 32'h0);
        chk("rst_flush", {31'h0, bus1.flush_o}, 32'h0);
        chk("rst_newpc", bus1.new_pc_o, 32'h0);
        chk("rst_addr", bus1.current_inst_addr_o, 32'h0);
        chk("rst_int_sync", {26'h0, bus1.int_sync_o}, 32'h0);

        // syscall in a delay slot
        rst = 1'b1;
        bus1.cp0_status_i      = 32'h10000000;
        bus1.inst_valid_i      = 1'b1;
        bus1.excepttype_raw_i  = 32'h00000100;
        bus1.inst_addr_i       = 32'h00000100;
        bus1.is_in_delayslot_i = 1'b1;
        step();
        chk("sys_exc", bus1.excepttype_o, 32'h8);
        chk("sys_addr", bus1.current_inst_addr_o, 32'h100);
        chk("sys_ds", {31'h0, bus1.is_in_delayslot_o}, 32'h1);
        chk("sys_flush", {31'h0, bus1.flush_o}, 32'h1);
        chk("sys_newpc", bus1.new_pc_o, 32'h20);
        bus1.excepttype_raw_i  = 32'h0;
        bus1.is_in_delayslot_i = 1'b0;
        bus1.inst_addr_i       = 32'h0;
        step();
        chk("sys_flush_end", {31'h0, bus1.flush_o}, 32'h0);
        chk("sys_exc_end", bus1.excepttype_o, 32'h0);
        chk("sys_newpc_end", bus1.new_pc_o, 32'h0);
        chk("sys_addr_hold", bus1.current_inst_addr_o, 32'h100);
        chk("sys_ds_hold", {31'h0, bus1.is_in_delayslot_o}, 32'h1);
        chk("sys3_flush_held", {31'h0, bus3.flush_o}, 32'h1);
        step(2);
        chk("sys3_flush_end", {31'h0, bus3.flush_o}, 32'h0);

        // eret with epc forwarded from WB-stage mtc0
        bus1.cp0_epc_i        = 32'h00000200;
        bus1.wb_cp0_we_i      = 1'b1;
        bus1.wb_cp0_waddr_i   = 5'd14;
        bus1.wb_cp0_data_i    = 32'h00000300;
        bus1.excepttype_raw_i = 32'h00001000;
        bus1.inst_addr_i      = 32'h00000180;
        step();
        chk("eret_exc", bus1.excepttype_o, 32'he);
        chk("eret_newpc", bus1.new_pc_o, 32'h300);
        chk("eret_addr", bus1.current_inst_addr_o, 32'h180);
        bus1.excepttype_raw_i = 32'h0;
        bus1.wb_cp0_we_i      = 1'b0;
        step(3);

        // interrupt beats syscall
        bus1.cp0_status_i     = 32'h00000401;
        bus1.cp0_cause_i      = 32'h00000400;
        bus1.excepttype_raw_i = 32'h00000100;
        step();
        chk("int_exc", bus1.excepttype_o, 32'h1);
        chk("int_newpc", bus1.new_pc_o, 32'h20);
        bus1.excepttype_raw_i = 32'h0;
        bus1.cp0_cause_i      = 32'h0;
        step(3);

        // exception level set masks the interrupt
        bus1.cp0_cause_i      = 32'h00000400;
        bus1.cp0_status_i     = 32'h00000403;
        bus1.excepttype_raw_i = 32'h00000100;
        step();
        chk("exl_exc", bus1.excepttype_o, 32'h8);
        bus1.excepttype_raw_i = 32'h0;
        bus1.cp0_cause_i      = 32'h0;
        bus1.cp0_status_i     = 32'h10000000;
        step(3);

        // overflow with FLUSH_CYCLES=3, syscall during flush ignored
        bus1.excepttype_raw_i = 32'h00000800;
        step();
        chk("ov3_exc", bus3.excepttype_o, 32'hc);
        chk("ov3_flush1", {31'h0, bus3.flush_o}, 32'h1);
        bus1.excepttype_raw_i = 32'h0;
        step();
        chk("ov3_flush2", {31'h0, bus3.flush_o}, 32'h1);
        chk("ov3_exc2", bus3.excepttype_o, 32'h0);
        bus1.excepttype_raw_i = 32'h00000100;
        step();
        chk("ov3_flush3", {31'h0, bus3.flush_o}, 32'h1);
        chk("ov3_ignored", bus3.excepttype_o, 32'h0);
        chk("ov3_newpc_held", bus3.new_pc_o, 32'h20);
        chk("ov1_resumed", bus1.excepttype_o, 32'h8);
        bus1.excepttype_raw_i = 32'h0;
        step();
        chk("ov3_flush_end", {31'h0, bus3.flush_o}, 32'h0);
        chk("ov3_exc_end", bus3.excepttype_o, 32'h0);
        step(3);

        // stall holds off detection until released
        bus1.excepttype_raw_i = 32'h00000200;
        bus1.stall_i          = 1'b1;
        step();
        chk("stall_exc", bus1.excepttype_o, 32'h0);
        chk("stall_flush", {31'h0, bus1.flush_o}, 32'h0);
        step();
        chk("stall_exc2", bus1.excepttype_o, 32'h0);
        bus1.stall_i = 1'b0;
        step();
        chk("unstall_exc", bus1.excepttype_o, 32'ha);
        bus1.excepttype_raw_i = 32'h0;
        step(3);

        // bubble and unrecognised flag are ignored
        bus1.inst_valid_i     = 1'b0;
        bus1.excepttype_raw_i = 32'h00000200;
        step();
        chk("bubble_flush", {31'h0, bus1.flush_o}, 32'h0);
        chk("bubble_exc", bus1.excepttype_o, 32'h0);
        bus1.inst_valid_i     = 1'b1;
        bus1.excepttype_raw_i = 32'h00000001;
        step();
        chk("unrec_flush", {31'h0, bus1.flush_o}, 32'h0);
        bus1.excepttype_raw_i = 32'h0;

        // interrupt line passthrough / synchronizer latency
        bus1.int_i = 6'b000001;
`ifdef EXC_CTRL_INT_SYNC_EN
        #1;
        chk("isync_t0", {26'h0, bus1.int_sync_o}, 32'h0);
        step();
        chk("isync_t1", {26'h0, bus1.int_sync_o}, 32'h0);
        step();
        chk("isync_t2", {26'h0, bus1.int_sync_o}, 32'h1);
`else
        #1;
        chk("isync_comb", {26'h0, bus1.int_sync_o}, 32'h1);
        step();
        chk("isync_comb_hold", {26'h0, bus1.int_sync_o}, 32'h1);
`endif
        bus1.int_i = 6'h0;

        // reset during flush aborts it
        bus1.excepttype_raw_i = 32'h00000100;
        step();
        chk("rstf_flush_on", {31'h0, bus3.flush_o}, 32'h1);
        bus1.excepttype_raw_i = 32'h0;
        rst = 1'b0;
        step();
        chk("rstf_flush3", {31'h0, bus3.flush_o}, 32'h0);
        chk("rstf_exc3", bus3.excepttype_o, 32'h0);
        chk("rstf_flush1", {31'h0, bus1.flush_o}, 32'h0);
        chk("rstf_newpc3", bus3.new_pc_o, 32'h0);
        rst = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception resolver and pipeline flush controller; sits directly upstream of the CP0 register file.
- Each cycle it collects per-instruction exception flags, pending interrupts and forwarded CP0 state.
- It selects one exception by priority and drives the CP0 exception inputs: excepttype, current instruction address and delay-slot flag.
- It also sequences the pipeline flush and PC redirect.
- It synchronizes raw hardware interrupt lines before they reach the CP0 cause register.

Parameters:
EXC_VECTOR, 32'h00000020, handler entry PC for every exception except eret
FLUSH_CYCLES, 1, cycles flush_o stays high per exception (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
int_i  in  6  raw external interrupt lines
int_sync_o  out  6  synchronized interrupts, to CP0 int_i
excepttype_raw_i  in  32  flags: [8] syscall, [9] invalid inst, [10] trap, [11] overflow, [12] eret; other bits ignored
inst_addr_i  in  32  PC of the MEM-stage instruction
is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot
inst_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
stall_i  in  1  MEM stage stalled this cycle
cp0_status_i  in  32  CP0 status
cp0_cause_i  in  32  CP0 cause
cp0_epc_i  in  32  CP0 epc
wb_cp0_we_i  in  1  WB-stage mtc0 pending
wb_cp0_waddr_i  in  5  WB-stage mtc0 target register
wb_cp0_data_i  in  32  WB-stage mtc0 data
excepttype_o  out  32  to CP0 excepttype_i
current_inst_addr_o  out  32  to CP0 current_inst_addr_i
is_in_delayslot_o  out  1  to CP0 is_in_delayslot_i
flush_o  out  1  flush all pipeline registers
new_pc_o  out  32  redirect PC, valid while flush_o=1

Behaviour:
- Reset (rst==0 at clk edge):
  - All outputs go to 0; state goes to IDLE; flush counter goes to 0; synchronizer flops go to 0.
  - Reset mid-FLUSH aborts the flush: flush_o=0 on the next cycle.
- Forwarding (combinational):
  - status_f = wb_cp0_data_i when wb_cp0_we_i and waddr==12, else cp0_status_i.
  - epc_f: same rule with waddr 14.
  - cause_f: cp0_cause_i with bits [9:8] replaced by wb data when waddr==13.
- Detection is enabled only when state==IDLE, inst_valid_i==1 and stall_i==0. Priority, highest first:
  - interrupt, code 32'h1: (cause_f[15:8] & status_f[15:8]) != 0, status_f[1]==0 and status_f[0]==1
  - syscall, 32'h8
  - invalid instruction, 32'ha
  - trap, 32'hd
  - overflow, 32'hc
  - eret, 32'he
- States: IDLE and FLUSH.
- IDLE, when an exception is detected in cycle T, the following hold in cycle T+1:
  - excepttype_o = code for exactly one cycle.
  - current_inst_addr_o = inst_addr_i and is_in_delayslot_o = is_in_delayslot_i, both captured at T.
  - flush_o = 1.
  - new_pc_o = epc_f captured at T for eret, else EXC_VECTOR.
  - State goes to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH:
  - flush_o=1 and new_pc_o is held; excepttype_o=0.
  - The counter decrements each cycle. On the cycle the counter is 0, the next state is IDLE.
  - New detections are ignored.
- Leaving FLUSH: flush_o=0 and new_pc_o=0. current_inst_addr_o and is_in_delayslot_o keep their last values.
- Interrupt synchronizer:
  - Two flops per line; int_sync_o lags int_i by 2 cycles.
  - Runs in every state, including during stall and flush.
- stall_i high in IDLE: no detection and no output change. The flags are re-evaluated once the stall drops.
- If excepttype_raw_i has no recognised bit set and no interrupt is pending, nothing happens.

Optional Feature:
- Macro: EXC_CTRL_INT_SYNC_EN.
- Defined: the two-flop synchronizer is present, as described above.
- Undefined: int_sync_o = int_i combinationally (for a synchronous interrupt source). Everything else is unchanged.

Test Plan:
- Syscall: rst released, status=32'h10000000, inst_valid=1, excepttype_raw[8]=1, inst_addr=32'h100 -> next cycle excepttype_o=32'h8, current_inst_addr_o=32'h100, flush_o=1, new_pc_o=32'h20; flush_o=0 one cycle later.
- Eret with forwarding: cp0_epc_i=32'h200, wb_cp0_we=1, waddr=14, wb_data=32'h300, raw[12]=1 -> excepttype_o=32'he, new_pc_o=32'h300.
- Interrupt priority: status=32'h00000401, cause[10]=1, raw[8]=1 -> excepttype_o=32'h1 (not 8). The same with status[1]=1 -> excepttype_o=32'h8.
- FLUSH_CYCLES=3, overflow at T -> flush_o high for T+1..T+3. A syscall asserted at T+2 is ignored: excepttype_o stays 0.
- Stall and bubble: raw[9]=1 with stall_i=1 -> no response. Drop the stall -> excepttype_o=32'ha next cycle. inst_valid_i=0 -> no response.
- Interrupt sync and reset: int_i=6'b000001 at T -> int_sync_o=1 at T+2. Assert rst during FLUSH -> flush_o=0 and excepttype_o=0 next cycle.
